// File: rtl/bram_stream_loader.sv
// Byte-stream loader that writes framed program/data images into the BRAM port-B
// init interfaces and holds the CPU in reset until a frame commits cleanly.
module bram_stream_loader #(
  parameter int         ADDR_W    = 15,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic [3:0]        mem_we,
  output logic              instr_mem_en,
  output logic              data_mem_en,
  output logic              cpu_reset_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_TARGET, ST_LEN0, ST_LEN1, ST_DATA, ST_WRITE, ST_CHECK, ST_ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t              state_r, next_s;
  logic                target_r;
  logic [15:0]         count_r;
  logic [ADDR_W:0]     idx_r;
  logic [ADDR_W:0]     idx_next_s;
  logic [1:0]          lane_r;
  logic [23:0]         word_r;
  logic [7:0]          chk_r;
  logic                s_ready_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [31:0]         mem_data_r;
  logic [3:0]          mem_we_r;
  logic                instr_en_r, data_en_r;
  logic                cpu_reset_r, done_r, error_r;
  logic                accept_s;
  logic [15:0]         count_full_s;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign accept_s     = s_valid && s_ready_r;
  assign count_full_s = {s_data, count_r[7:0]};
  assign idx_next_s   = idx_r + (ADDR_W+1)'(1);

  // Next-state decode for the frame parser.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && s_data == SYNC_BYTE) next_s = ST_TARGET;
        else                                  next_s = ST_IDLE;
      end
      ST_TARGET: begin
        if (accept_s) begin
          if (s_data == 8'h00 || s_data == 8'h01) next_s = ST_LEN0;
          else                                     next_s = ST_ERROR;
        end else begin
          next_s = ST_TARGET;
        end
      end
      ST_LEN0: begin
        if (accept_s) next_s = ST_LEN1;
        else          next_s = ST_LEN0;
      end
      ST_LEN1: begin
        if (accept_s) begin
          if ({1'b0, count_full_s} > MAX_WORDS) next_s = ST_ERROR;
          else if (count_full_s == 16'd0)       next_s = ST_CHECK;
          else                                  next_s = ST_DATA;
        end else begin
          next_s = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (accept_s && lane_r == 2'd3) next_s = ST_WRITE;
        else                            next_s = ST_DATA;
      end
      ST_WRITE: begin
        if (17'(idx_next_s) < {1'b0, count_r}) next_s = ST_DATA;
        else                                   next_s = ST_CHECK;
      end
      ST_CHECK: begin
        if (accept_s) begin
          if (s_data == chk_r) next_s = ST_IDLE;
          else                 next_s = ST_ERROR;
        end else begin
          next_s = ST_CHECK;
        end
      end
      ST_ERROR: next_s = ST_IDLE;
      default:  next_s = ST_IDLE;
    endcase
  end

  // State register, frame datapath and registered BRAM/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      target_r    <= 1'b0;
      count_r     <= 16'd0;
      idx_r       <= '0;
      lane_r      <= 2'd0;
      word_r      <= 24'd0;
      chk_r       <= 8'd0;
      s_ready_r   <= 1'b1;
      mem_addr_r  <= '0;
      mem_data_r  <= 32'd0;
      mem_we_r    <= 4'h0;
      instr_en_r  <= 1'b0;
      data_en_r   <= 1'b0;
      cpu_reset_r <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      state_r    <= next_s;
      s_ready_r  <= (next_s != ST_WRITE) && (next_s != ST_ERROR);
      mem_we_r   <= 4'h0;
      instr_en_r <= 1'b0;
      data_en_r  <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s && s_data == SYNC_BYTE) begin
            cpu_reset_r <= 1'b1;
            error_r     <= 1'b0;
            chk_r       <= 8'd0;
            idx_r       <= '0;
            lane_r      <= 2'd0;
          end
        end
        ST_TARGET: if (accept_s) target_r <= s_data[0];
        ST_LEN0:   if (accept_s) count_r[7:0] <= s_data;
        ST_LEN1:   if (accept_s) count_r[15:8] <= s_data;
        ST_DATA: begin
          if (accept_s) begin
            chk_r  <= chk_update(chk_r, s_data);
            lane_r <= lane_r + 2'd1;
            case (lane_r)
              2'd0: word_r[7:0]   <= s_data;
              2'd1: word_r[15:8]  <= s_data;
              2'd2: word_r[23:16] <= s_data;
              default: begin
                // Launch the write straight from the last lane so the port is registered.
                mem_we_r   <= 4'hF;
                mem_data_r <= {s_data, word_r};
                mem_addr_r <= idx_r[ADDR_W-1:0];
                instr_en_r <= ~target_r;
                data_en_r  <= target_r;
              end
            endcase
          end
        end
        ST_WRITE: idx_r <= idx_next_s;
        ST_CHECK: begin
          if (accept_s && s_data == chk_r) begin
            done_r      <= 1'b1;
            cpu_reset_r <= 1'b0;
          end
        end
        ST_ERROR: error_r <= 1'b1;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  assign s_ready      = s_ready_r;
  assign mem_addr     = mem_addr_r;
  assign mem_data     = mem_data_r;
  assign mem_we       = mem_we_r;
  assign instr_mem_en = instr_en_r;
  assign data_mem_en  = data_en_r;
  assign cpu_reset_o  = cpu_reset_r;
  assign done_o       = done_r;
  assign error_o      = error_r;

endmodule
